regfile_wb_queue: RTL and testbench

Writeback queue that drives the write port of the 4-entry, 4-bit register file. It accepts writeback requests from the execute/memory side over a valid/ready handshake and buffers up to DEPTH of them in order. It drains one request per cycle into the register file's `reg_write`/`write_reg`/`write_data` port. It also forwards still-pending data to the two read ports, so readers never see a stale register value.

---
 rtl/regfile_wb_queue.sv | 141 ++++++++++++++
 tb/tb_regfile_wb_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// In-order writeback queue in front of the register file write port.
// Requests are accepted over a valid/ready handshake and buffered in a
// DEPTH-entry circular buffer. One entry drains per cycle into the
// register file's write port. Still-pending data is forwarded to the two
// register read ports, so readers never see a stale value.
//
// Build option:
//   REGFILE_WB_BYPASS_EN  defined   -> forwarding comparators are built
//                         undefined -> fwd_hit*/fwd_data* tied to 0; readers
//                                      must wait for idle
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     writeback request handshake
//   in_reg, in_data       destination register and value
//   wb_stall              hold the head this cycle (write port borrowed)
//   reg_write             register file write enable
//   write_reg/write_data  register file write address/data (head entry)
//   rd_addr1/rd_addr2     addresses currently being read from the regfile
//   fwd_hit1/fwd_hit2     a pending write exists for that read address
//   fwd_data1/fwd_data2   youngest pending data for that read address
//   idle                  queue empty
//
// All outputs are combinational from registered state and inputs.

module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_reg,
    input  logic [DW-1:0] in_data,
    input  logic          wb_stall,
    output logic          reg_write,
    output logic [AW-1:0] write_reg,
    output logic [DW-1:0] write_data,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2,
    output logic          idle
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // Entry storage; contents are never reset, only the pointers/count.
    logic [AW-1:0] ent_reg  [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic not_empty;
    logic push;
    logic pop;

    // Handshake and drain decode. A full queue stays not-ready even while
    // draining, so in_ready never depends on wb_stall.
    assign not_empty  = (count != '0);
    assign in_ready   = rst_n && (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign reg_write  = rst_n && not_empty && !wb_stall;
    assign pop        = reg_write;
    assign write_reg  = (rst_n && not_empty) ? ent_reg[rd_ptr]  : '0;
    assign write_data = (rst_n && not_empty) ? ent_data[rd_ptr] : '0;
    assign idle       = !rst_n || !not_empty;

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry write on accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[wr_ptr]  <= in_reg;
            ent_data[wr_ptr] <= in_data;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forwarding: walk valid entries oldest to youngest so the youngest
    // match is the one left standing. The draining head still counts;
    // the entry being pushed this cycle is not yet in storage.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (rst_n && (CW'(k) < count)) begin
                if (ent_reg[idx] == rd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_data[idx];
                end
                if (ent_reg[idx] == rd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_data[idx];
                end
            end
        end
    end
`else
    // No forwarding path; read addresses are intentionally unused.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_regfile_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;
    logic          wb_stall;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic          idle;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data),
        .wb_stall(wb_stall),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file stand-in fed by the DUT write port.
    logic          rf_clr;
    logic [DW-1:0] rf_dut [4];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf_dut[i] <= '0;
        end else if (reg_write) begin
            rf_dut[write_reg] <= write_data;
        end
    end

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_rdy, input int e_rw,
                             input int e_wreg, input int e_wdata, input int e_idle,
                             input int e_h1, input int e_d1, input int e_h2, input int e_d2);
        chk({tag, ".in_ready"},   32'(in_ready),   e_rdy);
        chk({tag, ".reg_write"},  32'(reg_write),  e_rw);
        chk({tag, ".write_reg"},  32'(write_reg),  e_wreg);
        chk({tag, ".write_data"}, 32'(write_data), e_wdata);
        chk({tag, ".idle"},       32'(idle),       e_idle);
        chk({tag, ".fwd_hit1"},   32'(fwd_hit1),   e_h1);
        chk({tag, ".fwd_data1"},  32'(fwd_data1),  e_d1);
        chk({tag, ".fwd_hit2"},   32'(fwd_hit2),   e_h2);
        chk({tag, ".fwd_data2"},  32'(fwd_data2),  e_d2);
    endtask

    task automatic drive(input int r, input int v, input int rg, input int dt,
                         input int st, input int a1, input int a2);
        rst_n    = r[0];
        in_valid = v[0];
        in_reg   = AW'(rg);
        in_data  = DW'(dt);
        wb_stall = st[0];
        rd_addr1 = AW'(a1);
        rd_addr2 = AW'(a2);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic int fw(input int x);
        return (HB != 0) ? x : 0;
    endfunction

    typedef struct {
        int rst, v, rg, dt, st, a1, a2;
        int e_rdy, e_rw, e_wreg, e_wdata, e_idle, e_h1, e_d1, e_h2, e_d2;
    } vec_t;

    typedef struct {
        int r;
        int d;
    } ent_t;

    vec_t vecs[14];
    ent_t mq[$];
    int   rf_m [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // rst v rg dt st a1 a2 | rdy rw wreg wdata idle h1 d1 h2 d2
        vecs[0]  = '{0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,    1, 0,  0,       0,  0};
        vecs[1]  = '{1, 1, 2, 'hA,  0, 2, 0,  1, 0, 0, 0,    1, 0,  0,       0,  0};
        vecs[2]  = '{1, 0, 0, 0,    0, 2, 0,  1, 1, 2, 'hA,  0, HB, fw('hA), 0,  0};
        vecs[3]  = '{1, 0, 0, 0,    0, 2, 0,  1, 0, 0, 0,    1, 0,  0,       0,  0};
        vecs[4]  = '{1, 1, 1, 3,    1, 1, 2,  1, 0, 0, 0,    1, 0,  0,       0,  0};
        vecs[5]  = '{1, 1, 1, 5,    1, 1, 2,  1, 0, 1, 3,    0, HB, fw(3),   0,  0};
        vecs[6]  = '{1, 1, 0, 7,    1, 1, 2,  1, 0, 1, 3,    0, HB, fw(5),   0,  0};
        vecs[7]  = '{1, 1, 3, 'hF,  1, 1, 2,  1, 0, 1, 3,    0, HB, fw(5),   0,  0};
        vecs[8]  = '{1, 1, 2, 9,    1, 1, 3,  0, 0, 1, 3,    0, HB, fw(5),   HB, fw('hF)};
        vecs[9]  = '{1, 1, 2, 9,    0, 1, 3,  0, 1, 1, 3,    0, HB, fw(5),   HB, fw('hF)};
        vecs[10] = '{1, 0, 0, 0,    0, 1, 3,  1, 1, 1, 5,    0, HB, fw(5),   HB, fw('hF)};
        vecs[11] = '{1, 0, 0, 0,    0, 1, 3,  1, 1, 0, 7,    0, 0,  0,       HB, fw('hF)};
        vecs[12] = '{1, 0, 0, 0,    0, 1, 3,  1, 1, 3, 'hF,  0, 0,  0,       HB, fw('hF)};
        vecs[13] = '{1, 0, 0, 0,    0, 1, 3,  1, 0, 0, 0,    1, 0,  0,       0,  0};

        // Power-up reset with the register file stand-in cleared.
        rf_clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        next_edge();
        next_edge();
        rf_clr = 1'b0;

        // Directed table: single write, fill under stall, forwarding,
        // full-plus-drain and in-order release.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].rg, vecs[i].dt,
                  vecs[i].st, vecs[i].a1, vecs[i].a2);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_rw,
                      vecs[i].e_wreg, vecs[i].e_wdata, vecs[i].e_idle,
                      vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2);
            next_edge();
        end
        chk("tbl.rf0", 32'(rf_dut[0]), 7);
        chk("tbl.rf1", 32'(rf_dut[1]), 5);
        chk("tbl.rf2", 32'(rf_dut[2]), 'hA);
        chk("tbl.rf3", 32'(rf_dut[3]), 'hF);

        // Simultaneous push/pop: preload two under stall, then push every
        // cycle; writes must come out back-to-back in push order.
        drive(1, 1, 0, 0, 1, 0, 0);
        next_edge();
        drive(1, 1, 1, 1, 1, 0, 0);
        next_edge();
        for (int j = 0; j < 6; j++) begin
            drive(1, 1, (j + 2) % 4, j + 2, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("pp%0d.in_ready", j),   32'(in_ready),   1);
            chk($sformatf("pp%0d.reg_write", j),  32'(reg_write),  1);
            chk($sformatf("pp%0d.write_reg", j),  32'(write_reg),  j % 4);
            chk($sformatf("pp%0d.write_data", j), 32'(write_data), j);
            next_edge();
        end
        for (int j = 6; j < 8; j++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("pp%0d.reg_write", j),  32'(reg_write),  1);
            chk($sformatf("pp%0d.write_data", j), 32'(write_data), j);
            next_edge();
        end
        @(negedge clk);
        chk("pp.idle", 32'(idle), 1);
        next_edge();

        // Reset mid-operation with three writes pending: nothing may land.
        drive(1, 1, 0, 2, 1, 0, 1);
        next_edge();
        drive(1, 1, 1, 3, 1, 0, 1);
        next_edge();
        drive(1, 1, 2, 4, 1, 0, 1);
        next_edge();
        drive(0, 1, 3, 8, 0, 0, 1);
        @(negedge clk);
        check_out("rstmid", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        next_edge();
        for (int j = 0; j < 3; j++) begin
            drive(1, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            check_out($sformatf("post_rst%0d", j), 1, 0, 0, 0, 1, 0, 0, 0, 0);
            next_edge();
        end
        chk("rst.rf0", 32'(rf_dut[0]), 4);
        chk("rst.rf1", 32'(rf_dut[1]), 5);
        chk("rst.rf2", 32'(rf_dut[2]), 6);
        chk("rst.rf3", 32'(rf_dut[3]), 7);

        // Randomized run against a queue model of the writeback path.
        rf_m[0] = 4; rf_m[1] = 5; rf_m[2] = 6; rf_m[3] = 7;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            int r, v, rg, dt, st, a1, a2;
            int e_rdy, e_rw, e_wreg, e_wdata, e_idle, e_h1, e_d1, e_h2, e_d2;
            r  = ($urandom_range(0, 39) != 0) ? 1 : 0;
            v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            st = ($urandom_range(0, 9) < ((c < 300) ? 6 : 2)) ? 1 : 0;
            rg = int'($urandom_range(0, 3));
            dt = int'($urandom_range(0, 15));
            a1 = int'($urandom_range(0, 3));
            a2 = int'($urandom_range(0, 3));
            drive(r, v, rg, dt, st, a1, a2);

            e_rdy   = (r != 0 && mq.size() < DEPTH) ? 1 : 0;
            e_rw    = (r != 0 && mq.size() != 0 && st == 0) ? 1 : 0;
            e_wreg  = (r != 0 && mq.size() != 0) ? mq[0].r : 0;
            e_wdata = (r != 0 && mq.size() != 0) ? mq[0].d : 0;
            e_idle  = (r == 0 || mq.size() == 0) ? 1 : 0;
            e_h1 = 0; e_d1 = 0; e_h2 = 0; e_d2 = 0;
            if (HB != 0 && r != 0) begin
                for (int k = mq.size() - 1; k >= 0; k--) begin
                    if (e_h1 == 0 && mq[k].r == a1) begin e_h1 = 1; e_d1 = mq[k].d; end
                    if (e_h2 == 0 && mq[k].r == a2) begin e_h2 = 1; e_d2 = mq[k].d; end
                end
            end
            @(negedge clk);
            check_out($sformatf("rnd%0d", c), e_rdy, e_rw, e_wreg, e_wdata, e_idle,
                      e_h1, e_d1, e_h2, e_d2);
            next_edge();

            if (r == 0) begin
                mq.delete();
            end else begin
                if (e_rw != 0) begin
                    rf_m[mq[0].r] = mq[0].d;
                    void'(mq.pop_front());
                end
                if (v != 0 && e_rdy != 0) mq.push_back('{rg, dt});
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rnd.rf%0d", i), 32'(rf_dut[i]), rf_m[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
